// File: rtl/interrupt_arbiter.sv
// interrupt_arbiter
//   Collects interrupt request pulses into a sticky pending register.
//   A per-line mask limits which pending lines may be chosen, and the
//   highest-index enabled line wins. The winner is offered to the core
//   over a valid/ack handshake. The accepted interrupt is then tracked
//   until the core signals completion. Nesting is not supported.

// priority_encoder
//   Returns the highest set index of req. on=1 when any bit of req is set.
//   Only indices below LINES can appear on out.
module priority_encoder #(
  parameter int OUT_WIDTH = 3,
  parameter int LINES     = 8
) (
  input  logic [LINES-1:0]     req,
  output logic [OUT_WIDTH-1:0] out,
  output logic                 on
);

  // Scan upward so that the last (highest) set bit is the one kept.
  always_comb begin
    out = '0;
    on  = 1'b0;
    for (int i = 0; i < LINES; i++) begin
      if (req[i]) begin
        out = OUT_WIDTH'(i);
        on  = 1'b1;
      end
    end
  end

endmodule

module interrupt_arbiter #(
  parameter int LINE_BITS = 3,
  parameter int LINES     = 1 << LINE_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [LINES-1:0]     irq_lines,
  input  logic                 mask_we,
  input  logic [LINES-1:0]     mask_in,
  input  logic                 int_enable,
  output logic                 int_valid,
  output logic [LINE_BITS-1:0] int_index,
  input  logic                 int_ack,
  output logic                 in_service,
  input  logic                 int_done,
  output logic [LINES-1:0]     pending
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OFFER   = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t                 state_reg;
  logic [LINES-1:0]       pending_reg;
  logic [LINES-1:0]       pending_next;
  logic [LINES-1:0]       mask_reg;
  logic [LINES-1:0]       sel;
  logic [LINES-1:0]       clr;
  logic [LINE_BITS-1:0]   enc_out;
  logic                   enc_on;
  logic                   ack_accept;

  // An ack only counts while an offer is outstanding.
  assign ack_accept = (state_reg == ST_OFFER) && int_ack;

  // Clear mask: the one-hot of the committed index, only on an accepted ack.
  generate
    for (genvar gi = 0; gi < LINES; gi++) begin : g_clr
      assign clr[gi] = ack_accept && (int_index == LINE_BITS'(gi));
    end
  endgenerate

  // The set is applied after the clear, so a new pulse on the line being
  // acknowledged keeps that line pending.
  assign pending_next = (pending_reg & ~clr) | irq_lines;

  // Selection comes only from registered state, so the request-to-offer path
  // takes two clock edges.
  assign sel     = pending_reg & mask_reg;
  assign pending = pending_reg;

  priority_encoder #(
    .OUT_WIDTH (LINE_BITS),
    .LINES     (LINES)
  ) u_prio (
    .req (sel),
    .out (enc_out),
    .on  (enc_on)
  );

  // Sticky pending register. The mask never clears bits here.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_reg <= '0;
    end else begin
      pending_reg <= pending_next;
    end
  end

  // Mask register. A new value is used by selection from the next cycle on.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_reg <= '0;
    end else if (mask_we) begin
      mask_reg <= mask_in;
    end
  end

  // Offer/service sequencer. It also drives the registered handshake outputs.
  // An offer is committed once made: index, mask and enable changes are
  // ignored until the ack arrives.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      int_valid  <= 1'b0;
      int_index  <= '0;
      in_service <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (int_enable && enc_on) begin
            state_reg <= ST_OFFER;
            int_valid <= 1'b1;
            int_index <= enc_out;
          end
        end
        ST_OFFER: begin
          if (int_ack) begin
            state_reg  <= ST_SERVICE;
            int_valid  <= 1'b0;
            in_service <= 1'b1;
          end
        end
        ST_SERVICE: begin
          if (int_done) begin
            state_reg  <= ST_IDLE;
            in_service <= 1'b0;
          end
        end
        default: begin
          state_reg  <= ST_IDLE;
          int_valid  <= 1'b0;
          in_service <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Testbench for interrupt_arbiter.
// The bench runs three phases:
//   1. A table of directed cycle vectors.
//   2. A hand-written check of reset while in service.
//   3. Randomized traffic compared against a behavioural model.
module tb_interrupt_arbiter;

  logic       clk;
  logic       reset;
  logic [7:0] irq_lines;
  logic       mask_we;
  logic [7:0] mask_in;
  logic       int_enable;
  logic       int_valid;
  logic [2:0] int_index;
  logic       int_ack;
  logic       in_service;
  logic       int_done;
  logic [7:0] pending;

  int tests_run;
  int tests_failed;

  interrupt_arbiter #(.LINE_BITS(3), .LINES(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_lines  (irq_lines),
    .mask_we    (mask_we),
    .mask_in    (mask_in),
    .int_enable (int_enable),
    .int_valid  (int_valid),
    .int_index  (int_index),
    .int_ack    (int_ack),
    .in_service (in_service),
    .int_done   (int_done),
    .pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] irq;
    logic       we;
    logic [7:0] mi;
    logic       en;
    logic       ack;
    logic       done;
    logic       ev;
    logic [2:0] ei;
    logic       es;
    logic [7:0] ep;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [7:0] irq, input logic we, input logic [7:0] mi,
                     input logic en, input logic ack, input logic done,
                     input logic ev, input logic [2:0] ei, input logic es,
                     input logic [7:0] ep);
    vec_t v;
    v.irq = irq; v.we = we; v.mi = mi; v.en = en; v.ack = ack; v.done = done;
    v.ev = ev; v.ei = ei; v.es = es; v.ep = ep;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, then sample the outputs 1 time unit after the edge.
  task automatic cycle(input logic rst, input logic [7:0] irq, input logic we,
                       input logic [7:0] mi, input logic en, input logic ack,
                       input logic done);
    reset = rst; irq_lines = irq; mask_we = we; mask_in = mi;
    int_enable = en; int_ack = ack; int_done = done;
    @(posedge clk);
    #1;
  endtask

  // Behavioural reference model, tracked as plain flags.
  bit       m_offered;
  bit       m_serving;
  int       m_idx;
  bit [7:0] m_pend;
  bit [7:0] m_mask;

  function automatic int highest(input bit [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_step(input bit rst, input bit [7:0] irq, input bit we,
                            input bit [7:0] mi, input bit en, input bit ack,
                            input bit done);
    bit [7:0] p_old;
    bit [7:0] m_old;
    int       win;
    if (rst) begin
      m_offered = 0; m_serving = 0; m_idx = 0; m_pend = 0; m_mask = 0;
      return;
    end
    p_old = m_pend;
    m_old = m_mask;
    if (m_offered && ack) m_pend[m_idx] = 1'b0;
    m_pend = m_pend | irq;
    if (we) m_mask = mi;
    if (m_offered) begin
      if (ack) begin
        m_offered = 0;
        m_serving = 1;
      end
    end else if (m_serving) begin
      if (done) m_serving = 0;
    end else begin
      win = highest(p_old & m_old);
      if (en && win >= 0) begin
        m_offered = 1;
        m_idx = win;
      end
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b1; irq_lines = '0; mask_we = 1'b0; mask_in = '0;
    int_enable = 1'b0; int_ack = 1'b0; int_done = 1'b0;

    // ---------------- Reset state ----------------
    cycle(1, 8'h00, 0, 8'h00, 0, 0, 0);
    cycle(1, 8'h00, 0, 8'h00, 0, 0, 0);
    chk("reset_valid", int_valid, 0);
    chk("reset_index", int_index, 0);
    chk("reset_in_service", in_service, 0);
    chk("reset_pending", pending, 0);

    // ---------------- Directed table ----------------
    //   irq   we  mi     en ack done ev idx es pend
    // Single request, mask opened in the first row.
    add(8'h00, 1, 8'hFF, 1, 0, 0,   0, 0, 0, 8'h00);
    add(8'h04, 0, 8'h00, 1, 0, 0,   0, 0, 0, 8'h04);
    add(8'h00, 0, 8'h00, 1, 0, 0,   1, 2, 0, 8'h04);
    add(8'h00, 0, 8'h00, 1, 1, 0,   0, 0, 1, 8'h00);
    add(8'h00, 0, 8'h00, 1, 0, 1,   0, 0, 0, 8'h00);
    // Two simultaneous requests: 7 wins, then 0 is offered after done.
    add(8'h81, 0, 8'h00, 1, 0, 0,   0, 0, 0, 8'h81);
    add(8'h00, 0, 8'h00, 1, 0, 0,   1, 7, 0, 8'h81);
    add(8'h00, 0, 8'h00, 1, 1, 0,   0, 0, 1, 8'h01);
    add(8'h00, 0, 8'h00, 1, 0, 1,   0, 0, 0, 8'h01);
    add(8'h00, 0, 8'h00, 1, 0, 0,   1, 0, 0, 8'h01);
    add(8'h00, 0, 8'h00, 1, 1, 0,   0, 0, 1, 8'h00);
    add(8'h00, 0, 8'h00, 1, 0, 1,   0, 0, 0, 8'h00);
    // Committed offer: a higher line arriving later does not displace index 2.
    add(8'h04, 0, 8'h00, 1, 0, 0,   0, 0, 0, 8'h04);
    add(8'h00, 0, 8'h00, 1, 0, 0,   1, 2, 0, 8'h04);
    add(8'h40, 0, 8'h00, 1, 0, 0,   1, 2, 0, 8'h44);
    add(8'h00, 0, 8'h00, 0, 0, 0,   1, 2, 0, 8'h44);
    add(8'h00, 0, 8'h00, 1, 1, 0,   0, 0, 1, 8'h40);
    add(8'h00, 0, 8'h00, 1, 0, 1,   0, 0, 0, 8'h40);
    add(8'h00, 0, 8'h00, 1, 0, 0,   1, 6, 0, 8'h40);
    add(8'h00, 0, 8'h00, 1, 1, 0,   0, 0, 1, 8'h00);
    add(8'h00, 0, 8'h00, 1, 0, 1,   0, 0, 0, 8'h00);
    // A masked line stays pending and is offered once unmasked.
    add(8'h00, 1, 8'hFB, 1, 0, 0,   0, 0, 0, 8'h00);
    add(8'h04, 0, 8'h00, 1, 0, 0,   0, 0, 0, 8'h04);
    add(8'h00, 0, 8'h00, 1, 0, 0,   0, 0, 0, 8'h04);
    add(8'h00, 0, 8'h00, 1, 0, 0,   0, 0, 0, 8'h04);
    add(8'h00, 1, 8'hFF, 1, 0, 0,   0, 0, 0, 8'h04);
    add(8'h00, 0, 8'h00, 1, 0, 0,   1, 2, 0, 8'h04);
    add(8'h00, 0, 8'h00, 1, 1, 0,   0, 0, 1, 8'h00);
    add(8'h00, 0, 8'h00, 1, 0, 1,   0, 0, 0, 8'h00);
    // int_enable low blocks new offers.
    add(8'h04, 0, 8'h00, 0, 0, 0,   0, 0, 0, 8'h04);
    add(8'h00, 0, 8'h00, 0, 0, 0,   0, 0, 0, 8'h04);
    add(8'h00, 0, 8'h00, 0, 0, 0,   0, 0, 0, 8'h04);
    add(8'h00, 0, 8'h00, 1, 0, 0,   1, 2, 0, 8'h04);
    add(8'h00, 0, 8'h00, 1, 1, 0,   0, 0, 1, 8'h00);
    add(8'h00, 0, 8'h00, 1, 0, 1,   0, 0, 0, 8'h00);
    // Set wins on ack, a stray ack in IDLE, and a stray done in OFFER.
    add(8'h08, 0, 8'h00, 1, 0, 0,   0, 0, 0, 8'h08);
    add(8'h00, 0, 8'h00, 1, 1, 0,   1, 3, 0, 8'h08);
    add(8'h00, 0, 8'h00, 1, 0, 1,   1, 3, 0, 8'h08);
    add(8'h08, 0, 8'h00, 1, 1, 0,   0, 0, 1, 8'h08);
    add(8'h00, 0, 8'h00, 1, 0, 1,   0, 0, 0, 8'h08);
    add(8'h00, 0, 8'h00, 1, 0, 0,   1, 3, 0, 8'h08);
    add(8'h00, 0, 8'h00, 1, 1, 0,   0, 0, 1, 8'h00);
    add(8'h00, 0, 8'h00, 1, 0, 1,   0, 0, 0, 8'h00);
    add(8'h00, 0, 8'h00, 1, 1, 0,   0, 0, 0, 8'h00);

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(0, vecs[i].irq, vecs[i].we, vecs[i].mi, vecs[i].en, vecs[i].ack, vecs[i].done);
      chk($sformatf("vec%0d_valid", i), int_valid, vecs[i].ev);
      if (vecs[i].ev) chk($sformatf("vec%0d_index", i), int_index, vecs[i].ei);
      chk($sformatf("vec%0d_in_service", i), in_service, vecs[i].es);
      chk($sformatf("vec%0d_pending", i), pending, vecs[i].ep);
      $display("[TB] vec %0d irq=%02h ack=%0d done=%0d -> valid=%0d idx=%0d svc=%0d pend=%02h",
               i, vecs[i].irq, vecs[i].ack, vecs[i].done, int_valid, int_index, in_service, pending);
    end

    // ---------------- Reset while in service ----------------
    cycle(0, 8'h20, 0, 8'h00, 1, 0, 0);
    cycle(0, 8'h00, 0, 8'h00, 1, 0, 0);
    chk("rst6_offer_index", int_index, 5);
    cycle(0, 8'h30, 0, 8'h00, 1, 1, 0);
    chk("rst6_in_service", in_service, 1);
    chk("rst6_pending_pre", pending, 8'h30);
    cycle(1, 8'h00, 0, 8'h00, 1, 0, 0);
    chk("rst6_valid", int_valid, 0);
    chk("rst6_index", int_index, 0);
    chk("rst6_svc", in_service, 0);
    chk("rst6_pending", pending, 0);
    $display("[TB] reset-in-service: valid=%0d idx=%0d svc=%0d pend=%02h",
             int_valid, int_index, in_service, pending);

    // ---------------- Randomized traffic vs model ----------------
    model_step(1, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      bit       r_rst;
      bit [7:0] r_irq;
      bit       r_we;
      bit [7:0] r_mi;
      bit       r_en;
      bit       r_ack;
      bit       r_done;
      r_rst  = ($urandom_range(0, 199) == 0);
      r_irq  = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      if ($urandom_range(0, 15) == 0) r_irq = 8'($urandom);
      r_we   = ($urandom_range(0, 19) == 0);
      r_mi   = 8'($urandom) | 8'($urandom);
      r_en   = ($urandom_range(0, 7) != 0);
      r_ack  = ($urandom_range(0, 2) == 0);
      r_done = ($urandom_range(0, 2) == 0);
      model_step(r_rst, r_irq, r_we, r_mi, r_en, r_ack, r_done);
      cycle(r_rst, r_irq, r_we, r_mi, r_en, r_ack, r_done);
      chk("rnd_valid", int_valid, m_offered);
      if (m_offered) chk("rnd_index", int_index, m_idx);
      chk("rnd_in_service", in_service, m_serving);
      chk("rnd_pending", pending, m_pend);
      chk("rnd_exclusive", int_valid & in_service, 0);
      if (n % 100 == 0)
        $display("[TB] rnd %0d irq=%02h ack=%0d done=%0d -> valid=%0d idx=%0d svc=%0d pend=%02h",
                 n, r_irq, r_ack, r_done, int_valid, int_index, in_service, pending);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
